reorder_buffer: RTL and testbench

- In-order retirement queue between the decoder/issue stage and the architectural register file.
- Hands a 4-bit ROB tag to each decoded instruction and captures results from the common data bus (CDB).
- Retires at most one entry per cycle by driving the register file's commit write port.
- On a mispredicted branch it drives the rollback flush and supplies the corrected PC.

---
 rtl/reorder_buffer_if.sv | 53 +++++
 rtl/reorder_buffer.sv | 123 ++++++++++++
 tb/tb_reorder_buffer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: decoder/CDB/commit signals of the reorder buffer.
// commit_count exists only when ROB_COMMIT_COUNT_EN is defined.
interface reorder_buffer_if #(parameter int W = 4);
    logic        rdy;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_is_branch;
    logic        alloc_is_store;
    logic [W-1:0] rob_need;
    logic        rob_full;
    logic        cdb_valid;
    logic [W-1:0] cdb_rob_id;
    logic [31:0] cdb_val;
    logic        cdb_mispredict;
    logic [31:0] cdb_target;
    logic [W-1:0] q1_id, q2_id;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_val, q2_val;
    logic        commit_config;
    logic [4:0]  rs_to_write_id;
    logic [31:0] rs_to_write_val;
    logic [W-1:0] commit_rob_id;
    logic        store_commit;
    logic        rollback_config;
    logic [31:0] rollback_pc;
`ifdef ROB_COMMIT_COUNT_EN
    logic [31:0] commit_count;
`endif

    modport master (
`ifdef ROB_COMMIT_COUNT_EN
        input  commit_count,
`endif
        output rdy, alloc_valid, alloc_rd, alloc_is_branch, alloc_is_store,
        output cdb_valid, cdb_rob_id, cdb_val, cdb_mispredict, cdb_target,
        output q1_id, q2_id,
        input  rob_need, rob_full, q1_ready, q2_ready, q1_val, q2_val,
        input  commit_config, rs_to_write_id, rs_to_write_val, commit_rob_id,
        input  store_commit, rollback_config, rollback_pc
    );

    modport slave (
`ifdef ROB_COMMIT_COUNT_EN
        output commit_count,
`endif
        input  rdy, alloc_valid, alloc_rd, alloc_is_branch, alloc_is_store,
        input  cdb_valid, cdb_rob_id, cdb_val, cdb_mispredict, cdb_target,
        input  q1_id, q2_id,
        output rob_need, rob_full, q1_ready, q2_ready, q1_val, q2_val,
        output commit_config, rs_to_write_id, rs_to_write_val, commit_rob_id,
        output store_commit, rollback_config, rollback_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue with CDB capture, operand bypass and mispredict rollback.
// Optional retired-entry counter enabled by ROB_COMMIT_COUNT_EN.
module reorder_buffer #(parameter int ROB_DEPTH_LOG = 4) (
    input logic clk,
    input logic rst,
    reorder_buffer_if.slave rob
);
    localparam int N = 1 << ROB_DEPTH_LOG;
    localparam int CW = ROB_DEPTH_LOG + 1;

    logic [N-1:0]          r_busy, r_ready, r_is_br, r_is_st, r_mis;
    logic [4:0]            r_rd  [N];
    logic [31:0]           r_val [N];
    logic [31:0]           r_tgt [N];
    logic [ROB_DEPTH_LOG-1:0] r_head, r_tail, r_commit_rob_id;
    logic [CW-1:0]         r_count;
    logic                  r_commit_config, r_store_commit, r_rollback_config;
    logic [4:0]            r_rs_id;
    logic [31:0]           r_rs_val, r_rollback_pc;
    logic                  w_commit, w_flush, w_full, w_alloc, w_wb;
    logic                  w_q1_byp, w_q2_byp;

    assign w_commit = (r_count != '0) && r_busy[r_head] && r_ready[r_head];
    assign w_flush  = w_commit && r_mis[r_head] && r_is_br[r_head];
    // a retiring head frees its slot this cycle, so the queue is no longer full
    assign w_full   = (r_count == CW'(N)) && !w_commit;
    assign w_alloc  = rob.alloc_valid && !w_full && !w_flush;
    assign w_wb     = rob.cdb_valid && r_busy[rob.cdb_rob_id] && !w_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy            <= '0;
            r_ready           <= '0;
            r_is_br           <= '0;
            r_is_st           <= '0;
            r_mis             <= '0;
            for (int i = 0; i < N; i++) begin
                r_rd[i]  <= '0;
                r_val[i] <= '0;
                r_tgt[i] <= '0;
            end
            r_head            <= '0;
            r_tail            <= '0;
            r_count           <= '0;
            r_commit_config   <= 1'b0;
            r_store_commit    <= 1'b0;
            r_rollback_config <= 1'b0;
            r_rs_id           <= '0;
            r_rs_val          <= '0;
            r_commit_rob_id   <= '0;
            r_rollback_pc     <= '0;
        end else if (rob.rdy) begin
            r_commit_config   <= 1'b0;
            r_store_commit    <= 1'b0;
            r_rollback_config <= 1'b0;
            if (w_commit) begin
                r_commit_config <= (r_rd[r_head] != 5'd0) && !r_is_st[r_head];
                r_store_commit  <= r_is_st[r_head];
                r_rs_id         <= r_rd[r_head];
                r_rs_val        <= r_val[r_head];
                r_commit_rob_id <= r_head;
                r_busy[r_head]  <= 1'b0;
            end
            if (w_flush) begin
                r_rollback_config <= 1'b1;
                r_rollback_pc     <= r_tgt[r_head];
                r_busy            <= '0;
                r_ready           <= '0;
                r_head            <= '0;
                r_tail            <= '0;
                r_count           <= '0;
            end else begin
                if (w_commit)
                    r_head <= r_head + 1'b1;
                if (w_wb) begin
                    r_ready[rob.cdb_rob_id] <= 1'b1;
                    r_val[rob.cdb_rob_id]   <= rob.cdb_val;
                    r_mis[rob.cdb_rob_id]   <= rob.cdb_mispredict;
                    r_tgt[rob.cdb_rob_id]   <= rob.cdb_target;
                end
                // allocation is written last so it wins when tail aliases the retiring head
                if (w_alloc) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_mis[r_tail]   <= 1'b0;
                    r_is_br[r_tail] <= rob.alloc_is_branch;
                    r_is_st[r_tail] <= rob.alloc_is_store;
                    r_rd[r_tail]    <= rob.alloc_rd;
                    r_tail          <= r_tail + 1'b1;
                end
                r_count <= r_count + CW'(w_alloc) - CW'(w_commit);
            end
        end
    end

`ifdef ROB_COMMIT_COUNT_EN
    logic [31:0] r_commit_count;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_commit_count <= '0;
        else if (rob.rdy && w_commit)
            r_commit_count <= r_commit_count + 32'd1;
    end
    assign rob.commit_count = r_commit_count;
`endif

    assign w_q1_byp = rob.cdb_valid && (rob.cdb_rob_id == rob.q1_id);
    assign w_q2_byp = rob.cdb_valid && (rob.cdb_rob_id == rob.q2_id);

    assign rob.q1_ready        = w_q1_byp ? 1'b1 : r_ready[rob.q1_id];
    assign rob.q1_val          = w_q1_byp ? rob.cdb_val : r_val[rob.q1_id];
    assign rob.q2_ready        = w_q2_byp ? 1'b1 : r_ready[rob.q2_id];
    assign rob.q2_val          = w_q2_byp ? rob.cdb_val : r_val[rob.q2_id];
    assign rob.rob_need        = r_tail;
    assign rob.rob_full        = w_full;
    assign rob.commit_config   = r_commit_config;
    assign rob.rs_to_write_id  = r_rs_id;
    assign rob.rs_to_write_val = r_rs_val;
    assign rob.commit_rob_id   = r_commit_rob_id;
    assign rob.store_commit    = r_store_commit;
    assign rob.rollback_config = r_rollback_config;
    assign rob.rollback_pc     = r_rollback_pc;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: table-driven directed checks of the reorder buffer plus full/reset/stall sequences.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    reorder_buffer_if bus ();
    reorder_buffer dut (.clk(clk), .rst(rst), .rob(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  rd;
        logic        br, st, cv;
        logic [3:0]  cid;
        logic [31:0] cval;
        logic        mis;
        logic [31:0] tgt;
        logic        qc;
        logic [3:0]  qid;
        logic        qr;
        logic [31:0] qv;
    } vin_t;

    typedef struct packed {
        logic        cfg;
        logic [4:0]  wid;
        logic [31:0] wval;
        logic [3:0]  cid;
        logic        st, rb;
        logic [31:0] pc;
        logic [3:0]  need;
        logic        full;
    } exp_t;

    typedef struct {
        vin_t i;
        exp_t e;
    } vec_t;

    function automatic vin_t vi(int av, int rd, int br, int st, int cv, int cid, int cval,
                                int mis, int tgt, int qc, int qid, int qr, int qv);
        vin_t r;
        r.av = av[0]; r.rd = rd[4:0]; r.br = br[0]; r.st = st[0];
        r.cv = cv[0]; r.cid = cid[3:0]; r.cval = cval; r.mis = mis[0]; r.tgt = tgt;
        r.qc = qc[0]; r.qid = qid[3:0]; r.qr = qr[0]; r.qv = qv;
        return r;
    endfunction

    function automatic exp_t ve(int cfg, int wid, int wval, int cid, int st, int rb,
                                int pc, int need, int full);
        exp_t r;
        r.cfg = cfg[0]; r.wid = wid[4:0]; r.wval = wval; r.cid = cid[3:0];
        r.st = st[0]; r.rb = rb[0]; r.pc = pc; r.need = need[3:0]; r.full = full[0];
        return r;
    endfunction

    function automatic exp_t got();
        exp_t r;
        r.cfg = bus.commit_config; r.wid = bus.rs_to_write_id; r.wval = bus.rs_to_write_val;
        r.cid = bus.commit_rob_id; r.st = bus.store_commit; r.rb = bus.rollback_config;
        r.pc = bus.rollback_pc; r.need = bus.rob_need; r.full = bus.rob_full;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic apply(input vin_t v);
        bus.alloc_valid = v.av; bus.alloc_rd = v.rd;
        bus.alloc_is_branch = v.br; bus.alloc_is_store = v.st;
        bus.cdb_valid = v.cv; bus.cdb_rob_id = v.cid; bus.cdb_val = v.cval;
        bus.cdb_mispredict = v.mis; bus.cdb_target = v.tgt;
        bus.q1_id = v.qid; bus.q2_id = v.qid;
    endtask

    task automatic chk_q(input string nm, input vin_t v);
        chk(nm, {bus.q1_ready, bus.q1_val, bus.q2_ready, bus.q2_val}, {v.qr, v.qv, v.qr, v.qv});
    endtask

    task automatic step(input vin_t v);
        @(negedge clk);
        apply(v);
        #1;
        if (v.qc) chk_q("query", v);
        @(posedge clk);
        #1;
    endtask

    vec_t tv[26];
    vin_t idle;

    initial begin
        idle = vi(0,0,0,0, 0,0,0,0,0, 0,0,0,0);
        //        av rd br st  cv cid cval    mis tgt      qc qid qr qv                cfg wid wval     cid st rb pc      need full
        tv[0]  = '{vi(1, 5,0,0, 0,0,0,      0,0,       0,0,0,0),        ve(0,0,0,      0,0,0,0,      1,0)};
        tv[1]  = '{vi(0, 0,0,0, 1,0,'h1234, 0,0,       0,0,0,0),        ve(0,0,0,      0,0,0,0,      1,0)};
        tv[2]  = '{idle,                                                ve(1,5,'h1234, 0,0,0,0,      1,0)};
        tv[3]  = '{idle,                                                ve(0,5,'h1234, 0,0,0,0,      1,0)};
        tv[4]  = '{vi(1, 7,0,0, 0,0,0,      0,0,       0,0,0,0),        ve(0,5,'h1234, 0,0,0,0,      2,0)};
        tv[5]  = '{vi(1, 8,0,0, 0,0,0,      0,0,       0,0,0,0),        ve(0,5,'h1234, 0,0,0,0,      3,0)};
        tv[6]  = '{vi(0, 0,0,0, 1,2,'hB2,   0,0,       0,0,0,0),        ve(0,5,'h1234, 0,0,0,0,      3,0)};
        tv[7]  = '{idle,                                                ve(0,5,'h1234, 0,0,0,0,      3,0)};
        tv[8]  = '{vi(0, 0,0,0, 1,1,'hB1,   0,0,       0,0,0,0),        ve(0,5,'h1234, 0,0,0,0,      3,0)};
        tv[9]  = '{idle,                                                ve(1,7,'hB1,   1,0,0,0,      3,0)};
        tv[10] = '{idle,                                                ve(1,8,'hB2,   2,0,0,0,      3,0)};
        tv[11] = '{idle,                                                ve(0,8,'hB2,   2,0,0,0,      3,0)};
        tv[12] = '{vi(1, 1,1,0, 0,0,0,      0,0,       0,0,0,0),        ve(0,8,'hB2,   2,0,0,0,      4,0)};
        tv[13] = '{vi(1,10,0,0, 0,0,0,      0,0,       0,0,0,0),        ve(0,8,'hB2,   2,0,0,0,      5,0)};
        tv[14] = '{vi(1,11,0,0, 0,0,0,      0,0,       0,0,0,0),        ve(0,8,'hB2,   2,0,0,0,      6,0)};
        tv[15] = '{vi(1,12,0,0, 0,0,0,      0,0,       0,0,0,0),        ve(0,8,'hB2,   2,0,0,0,      7,0)};
        tv[16] = '{vi(0, 0,0,0, 1,3,'h44,   1,'h1000,  1,3,1,'h44),     ve(0,8,'hB2,   2,0,0,0,      7,0)};
        tv[17] = '{idle,                                                ve(1,1,'h44,   3,0,1,'h1000, 0,0)};
        tv[18] = '{vi(0, 0,0,0, 1,4,'h99,   0,0,       0,0,0,0),        ve(0,1,'h44,   3,0,0,'h1000, 0,0)};
        tv[19] = '{vi(1, 3,0,0, 0,0,0,      0,0,       0,0,0,0),        ve(0,1,'h44,   3,0,0,'h1000, 1,0)};
        tv[20] = '{vi(0, 0,0,0, 0,0,0,      0,0,       1,4,0,0),        ve(0,1,'h44,   3,0,0,'h1000, 1,0)};
        tv[21] = '{vi(0, 0,0,0, 1,0,'hDEAD, 0,0,       1,0,1,'hDEAD),   ve(0,1,'h44,   3,0,0,'h1000, 1,0)};
        tv[22] = '{vi(1, 0,0,1, 0,0,0,      0,0,       1,0,1,'hDEAD),   ve(1,3,'hDEAD, 0,0,0,'h1000, 2,0)};
        tv[23] = '{vi(0, 0,0,0, 1,1,'h55,   0,0,       1,1,1,'h55),     ve(0,3,'hDEAD, 0,0,0,'h1000, 2,0)};
        tv[24] = '{idle,                                                ve(0,0,'h55,   1,1,0,'h1000, 2,0)};
        tv[25] = '{vi(0, 0,0,0, 0,0,0,      0,0,       1,2,0,'hB2),     ve(0,0,'h55,   1,0,0,'h1000, 2,0)};

        bus.rdy = 1'b1;
        apply(idle);
        #12;
        chk("reset_out", got(), ve(0,0,0,0,0,0,0,0,0));
        chk_q("reset_q", idle);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 26; i++) begin
            step(tv[i].i);
            chk($sformatf("vec%0d", i), got(), tv[i].e);
        end

        // async reset with seven entries in flight (tags 2..8)
        for (int i = 0; i < 7; i++) step(vi(1,i+1,0,0, 0,0,0,0,0, 0,0,0,0));
        chk("pre_rst_need", bus.rob_need, 4'd9);
        apply(idle);
        bus.q1_id = 4'd2;
        bus.q2_id = 4'd2;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_out", got(), ve(0,0,0,0,0,0,0,0,0));
        chk_q("async_rst_q", vi(0,0,0,0, 0,0,0,0,0, 1,2,0,0));
        @(negedge clk);
        rst = 1'b1;

        // fill all sixteen slots, then push one more that must be dropped
        for (int i = 0; i < 16; i++) begin
            step(vi(1,i+1,0,0, 0,0,0,0,0, 0,0,0,0));
            if (i == 0) chk("first_tag", bus.rob_need, 4'd1);
        end
        chk("full_after16", {bus.rob_need, bus.rob_full}, {4'd0, 1'b1});
        step(vi(1,20,0,0, 0,0,0,0,0, 0,0,0,0));
        chk("alloc17_ignored", {bus.rob_need, bus.rob_full}, {4'd0, 1'b1});
        step(vi(0,0,0,0, 1,0,'h77,0,0, 0,0,0,0));
        chk("full_clears_on_commit", bus.rob_full, 1'b0);
        step(vi(1,21,0,0, 0,0,0,0,0, 0,0,0,0));
        chk("alloc_with_commit", got(), ve(1,1,'h77,0,0,0,0,1,1));

        // rdy low freezes state and registered outputs
        @(negedge clk);
        bus.rdy = 1'b0;
        step(vi(1,22,0,0, 1,1,'h66,0,0, 0,0,0,0));
        chk("rdy_hold", got(), ve(1,1,'h77,0,0,0,0,1,1));
        bus.rdy = 1'b1;
        step(idle);
        chk("rdy_resume", got(), ve(0,1,'h77,0,0,0,0,1,1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
